// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: round-robin arbiter that drives the common data bus (CDB)
// from NUM_UNITS functional units.
//
// Each cycle at most one requesting unit is granted. Its payload is registered
// onto the CDB, so the broadcast appears one cycle after the transfer. The
// registered CDB feeds the reservation stations, the ROB and the rename stage.
//
// Handshake (req/grant): a unit holds req high with a stable payload until it
// sees grant high in the same cycle. req & grant at a rising clk edge is a
// transfer. The unit may drop or replace req on the following cycle. grant is
// combinational and one-hot. It is forced to zero during flush, cdbStall or
// reset.
//
// Optional feature, compile-time macro CDB_GRANT_COUNT_EN: adds the grantCount
// output, which holds one 16-bit saturating transfer counter per unit.
module cdb_rr_arbiter #(
    parameter int WIDTH     = 31,  // MSB index of result/target
    parameter int ROB       = 2,   // MSB index of ROB tag
    parameter int NUM_UNITS = 4    // number of requesting units (>= 2)
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           flush,
    input  logic                           cdbStall,
    input  logic [NUM_UNITS-1:0]           req,
    input  logic [NUM_UNITS*(WIDTH+1)-1:0] unitResult,
    input  logic [NUM_UNITS*(ROB+1)-1:0]   unitRob,
    input  logic [NUM_UNITS*(WIDTH+1)-1:0] unitTarget,
    input  logic [NUM_UNITS-1:0]           unitIsControl,
    output logic [NUM_UNITS-1:0]           grant,
    output logic [WIDTH:0]                 cdbResult,
    output logic [ROB:0]                   cdbRob,
    output logic                           cdbValid,
    output logic [WIDTH:0]                 cdbTarget,
    output logic                           cdbIsControl
`ifdef CDB_GRANT_COUNT_EN
    ,
    output logic [NUM_UNITS*16-1:0]        grantCount
`endif
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NUM_UNITS - 1);

    // Round-robin pointer: the unit that has first claim on the next grant.
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Registered CDB broadcast.
    logic [WIDTH:0]   cdb_result_q;
    logic [ROB:0]     cdb_rob_q;
    logic             cdb_valid_q;
    logic [WIDTH:0]   cdb_target_q;
    logic             cdb_is_control_q;

    // Winner of the current search.
    logic             xfer;
    logic [PTR_W-1:0] win_idx;
    logic [WIDTH:0]   win_result;
    logic [ROB:0]     win_rob;
    logic [WIDTH:0]   win_target;
    logic             win_is_control;

    // Search req from ptr_q upward with wrap-around. The first hit wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        xfer    = 1'b0;
        win_idx = '0;
        grant   = '0;
        idx     = 0;
        cand    = '0;
        if (resetN && !flush && !cdbStall) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_UNITS) begin
                    idx = idx - NUM_UNITS;
                end
                cand = PTR_W'(idx);
                if (!xfer && req[cand]) begin
                    xfer    = 1'b1;
                    win_idx = cand;
                end
            end
            if (xfer) begin
                grant[win_idx] = 1'b1;
            end
        end
    end

    // Select the winning unit's payload slices.
    always_comb begin
        win_result     = unitResult[int'(win_idx)*(WIDTH+1) +: (WIDTH+1)];
        win_rob        = unitRob[int'(win_idx)*(ROB+1) +: (ROB+1)];
        win_target     = unitTarget[int'(win_idx)*(WIDTH+1) +: (WIDTH+1)];
        win_is_control = unitIsControl[win_idx];
    end

    // Next pointer: one past the winner, wrapping explicitly so that
    // non-power-of-two unit counts stay in range.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win_idx == LAST_UNIT) ? '0 : win_idx + 1'b1;
        end
    end

    // Pointer register. xfer is already low under flush/stall, so it holds then.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // CDB output register. Flush beats stall, stall freezes the broadcast,
    // an idle cycle drops valid but keeps the data bits.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cdb_result_q     <= '0;
            cdb_rob_q        <= '0;
            cdb_valid_q      <= 1'b0;
            cdb_target_q     <= '0;
            cdb_is_control_q <= 1'b0;
        end else if (flush) begin
            cdb_valid_q      <= 1'b0;
            cdb_is_control_q <= 1'b0;
        end else if (cdbStall) begin
            cdb_valid_q      <= cdb_valid_q;
            cdb_is_control_q <= cdb_is_control_q;
        end else if (xfer) begin
            cdb_valid_q      <= 1'b1;
            cdb_result_q     <= win_result;
            cdb_rob_q        <= win_rob;
            cdb_is_control_q <= win_is_control;
            // Target is only meaningful for control flow. Keep the last one otherwise.
            if (win_is_control) begin
                cdb_target_q <= win_target;
            end
        end else begin
            cdb_valid_q      <= 1'b0;
            cdb_is_control_q <= 1'b0;
        end
    end

    assign cdbResult    = cdb_result_q;
    assign cdbRob       = cdb_rob_q;
    assign cdbValid     = cdb_valid_q;
    assign cdbTarget    = cdb_target_q;
    assign cdbIsControl = cdb_is_control_q;

`ifdef CDB_GRANT_COUNT_EN
    logic [15:0] grant_cnt_q [NUM_UNITS];

    // Per-unit saturating transfer counters. Only reset clears them, not flush.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (grant[i] && req[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Pack the counters onto the flat output bus, unit i at slice i.
    always_comb begin
        grantCount = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            grantCount[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for cdb_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the CDB.
module tb_cdb_rr_arbiter;

  localparam int WIDTH = 31;
  localparam int ROB   = 2;
  localparam int N     = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                   flush, cdbStall;
  logic [N-1:0]           req, unitIsControl, grant;
  logic [N*(WIDTH+1)-1:0] unitResult, unitTarget;
  logic [N*(ROB+1)-1:0]   unitRob;
  logic [WIDTH:0]         cdbResult, cdbTarget;
  logic [ROB:0]           cdbRob;
  logic                   cdbValid, cdbIsControl;
`ifdef CDB_GRANT_COUNT_EN
  logic [N*16-1:0]        grantCount;
`endif

  // Per-unit payloads, packed onto the flat buses.
  logic [WIDTH:0] res_a [N];
  logic [WIDTH:0] tgt_a [N];
  logic [ROB:0]   rob_a [N];
  logic           ctl_a [N];

  always_comb begin
    unitResult    = '0;
    unitTarget    = '0;
    unitRob       = '0;
    unitIsControl = '0;
    for (int i = 0; i < N; i++) begin
      unitResult[i*(WIDTH+1) +: (WIDTH+1)] = res_a[i];
      unitTarget[i*(WIDTH+1) +: (WIDTH+1)] = tgt_a[i];
      unitRob[i*(ROB+1) +: (ROB+1)]        = rob_a[i];
      unitIsControl[i]                     = ctl_a[i];
    end
  end

  cdb_rr_arbiter #(.WIDTH(WIDTH), .ROB(ROB), .NUM_UNITS(N)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .flush        (flush),
    .cdbStall     (cdbStall),
    .req          (req),
    .unitResult   (unitResult),
    .unitRob      (unitRob),
    .unitTarget   (unitTarget),
    .unitIsControl(unitIsControl),
    .grant        (grant),
    .cdbResult    (cdbResult),
    .cdbRob       (cdbRob),
    .cdbValid     (cdbValid),
    .cdbTarget    (cdbTarget),
    .cdbIsControl (cdbIsControl)
`ifdef CDB_GRANT_COUNT_EN
    ,
    .grantCount   (grantCount)
`endif
  );

  // ---------------- reference model ----------------
  int             errors = 0;
  int             checks = 0;
  int             m_ptr;
  logic           m_valid, m_ctl;
  logic [WIDTH:0] m_res, m_tgt;
  logic [ROB:0]   m_rob;
  int             m_cnt [N];

  // The winner is the requester at the smallest rotational distance from the pointer.
  function automatic int model_winner();
    int best   = -1;
    int best_d = N;
    if (resetN && !flush && !cdbStall) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && ((k - m_ptr + N) % N) < best_d) begin
          best   = k;
          best_d = (k - m_ptr + N) % N;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g = '0;
    int w = model_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_ctl   = 1'b0;
    m_res   = '0;
    m_tgt   = '0;
    m_rob   = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Apply one rising edge to the model, using the inputs that were stable before it.
  task automatic model_edge();
    int w;
    if (!resetN) begin
      model_reset();
      return;
    end
    w = model_winner();
    if (flush) begin
      m_valid = 1'b0;
      m_ctl   = 1'b0;
    end else if (cdbStall) begin
      // the broadcast stays frozen
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_res   = res_a[w];
      m_rob   = rob_a[w];
      m_ctl   = ctl_a[w];
      if (ctl_a[w]) m_tgt = tgt_a[w];
      m_ptr   = (w + 1) % N;
      if (m_cnt[w] < 65535) m_cnt[w] = m_cnt[w] + 1;
    end else begin
      m_valid = 1'b0;
      m_ctl   = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    flush    = 1'b0;
    cdbStall = 1'b0;
    req      = '0;
    for (int i = 0; i < N; i++) begin
      res_a[i] = '0;
      tgt_a[i] = '0;
      rob_a[i] = '0;
      ctl_a[i] = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetN = 1'b0;
    drive_idle();
    req = 4'b1111;
    model_reset();
    #2;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b want 0000", grant);
    end
    checks++;
    if (cdbValid !== 1'b0 || cdbIsControl !== 1'b0 || cdbResult !== '0 || cdbRob !== '0 || cdbTarget !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b ctl=%b res=%h rob=%h tgt=%h want all zero",
                         cdbValid, cdbIsControl, cdbResult, cdbRob, cdbTarget);
    end
    tick();
    tick();
    resetN = 1'b1;
    req    = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000) begin
        errors++; $display("FAIL idle_grant: cycle %0d got %b want 0000", c, grant);
      end
      tick();
      checks++;
      if (cdbValid !== 1'b0) begin
        errors++; $display("FAIL idle_valid: cycle %0d got %b want 0", c, cdbValid);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) res_a[i] = 32'h100 + i;
    req = 4'b1111;
    for (int c = 0; c < N; c++) begin
      #1;
      exp_g = '0;
      exp_g[c] = 1'b1;
      checks++;
      if (grant !== exp_g || grant !== model_grant()) begin
        errors++; $display("FAIL rr_grant: step %0d got %b want %b", c, grant, exp_g);
      end
      tick();
      checks++;
      if (cdbValid !== 1'b1 || cdbResult !== 32'h100 + c) begin
        errors++; $display("FAIL rr_bcast: step %0d got valid=%b res=%h want 1/%h",
                           c, cdbValid, cdbResult, 32'h100 + c);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    req = 4'b0010;
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL wrap_setup: got %b want 0010", grant);
    end
    tick();
    req = 4'b0011;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL wrap_grant: got %b want 0001", grant);
    end
    tick();
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL wrap_next_ptr: got %b want 0010 (pointer 1)", grant);
    end
    tick();
    req = '0;
  endtask

  task automatic test_target_hold();
    tgt_a[3] = 32'h0000_0040;
    ctl_a[3] = 1'b1;
    res_a[3] = 32'h33;
    req = 4'b1000;
    #1;
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL tgt_grant3: got %b want 1000", grant);
    end
    tick();
    checks++;
    if (cdbTarget !== 32'h40 || cdbIsControl !== 1'b1 || cdbValid !== 1'b1) begin
      errors++; $display("FAIL tgt_ctl_bcast: got tgt=%h ctl=%b valid=%b want 40/1/1",
                         cdbTarget, cdbIsControl, cdbValid);
    end
    ctl_a[3] = 1'b0;
    tgt_a[0] = 32'hDEAD_BEEF;
    ctl_a[0] = 1'b0;
    res_a[0] = 32'h55;
    req = 4'b0001;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL tgt_grant0: got %b want 0001", grant);
    end
    tick();
    checks++;
    if (cdbTarget !== 32'h40 || cdbIsControl !== 1'b0 || cdbResult !== 32'h55) begin
      errors++; $display("FAIL tgt_hold: got tgt=%h ctl=%b res=%h want 40/0/55",
                         cdbTarget, cdbIsControl, cdbResult);
    end
    req = '0;
  endtask

  task automatic test_stall();
    rob_a[1] = 3'd5;
    rob_a[2] = 3'd2;
    req = 4'b0010;
    tick();
    checks++;
    if (cdbValid !== 1'b1 || cdbRob !== 3'd5) begin
      errors++; $display("FAIL stall_setup: got valid=%b rob=%0d want 1/5", cdbValid, cdbRob);
    end
    req      = 4'b0100;
    cdbStall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000) begin
        errors++; $display("FAIL stall_grant: cycle %0d got %b want 0000", c, grant);
      end
      tick();
      checks++;
      if (cdbValid !== 1'b1 || cdbRob !== 3'd5) begin
        errors++; $display("FAIL stall_hold: cycle %0d got valid=%b rob=%0d want 1/5", c, cdbValid, cdbRob);
      end
    end
    cdbStall = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL stall_release: got %b want 0100", grant);
    end
    tick();
    checks++;
    if (cdbValid !== 1'b1 || cdbRob !== 3'd2) begin
      errors++; $display("FAIL stall_bcast: got valid=%b rob=%0d want 1/2", cdbValid, cdbRob);
    end
    req = '0;
  endtask

  task automatic test_flush_reset();
    req   = 4'b1111;
    flush = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL flush_grant: got %b want 0000", grant);
    end
    tick();
    checks++;
    if (cdbValid !== 1'b0 || cdbIsControl !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got valid=%b ctl=%b want 0/0", cdbValid, cdbIsControl);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL flush_ptr_hold: got %b want 1000", grant);
    end
    tick();
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || cdbValid !== 1'b0 || cdbResult !== '0 || cdbRob !== '0 || cdbTarget !== '0) begin
      errors++; $display("FAIL async_reset: grant=%b valid=%b res=%h rob=%h tgt=%h want all zero",
                         grant, cdbValid, cdbResult, cdbRob, cdbTarget);
    end
    model_reset();
    tick();
    resetN = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL post_reset_ptr: got %b want 0001", grant);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom_range(0, (1 << N) - 1));
      cdbStall = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        res_a[i] = $urandom;
        tgt_a[i] = $urandom;
        rob_a[i] = ROB'($urandom_range(0, 7));
        ctl_a[i] = $urandom_range(0, 1);
      end
      #1;
      checks++;
      if (grant !== model_grant() || $countones(grant) > 1) begin
        errors++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, grant, model_grant());
      end
      tick();
      checks++;
      if (cdbValid !== m_valid || cdbIsControl !== m_ctl || cdbResult !== m_res ||
          cdbRob !== m_rob || cdbTarget !== m_tgt) begin
        errors++; $display("FAIL rand_cdb: cycle %0d got v=%b c=%b r=%h rob=%h t=%h want v=%b c=%b r=%h rob=%h t=%h",
                           c, cdbValid, cdbIsControl, cdbResult, cdbRob, cdbTarget,
                           m_valid, m_ctl, m_res, m_rob, m_tgt);
      end
`ifdef CDB_GRANT_COUNT_EN
      for (int k = 0; k < N; k++) begin
        checks++;
        if (grantCount[k*16 +: 16] !== 16'(m_cnt[k])) begin
          errors++; $display("FAIL rand_count: cycle %0d unit %0d got %0d want %0d",
                             c, k, grantCount[k*16 +: 16], m_cnt[k]);
        end
      end
`endif
    end
    drive_idle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_target_hold();
    test_stall();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
